// File: rtl/pll_meas_pkg.sv
// Shared constants for the PLL frequency meter: FSM state codes, default widths
// and the edge-detector flush length derived from the synchroniser depth.
package pll_meas_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEF_NCH         = 4;
  localparam int DEF_GATE_W      = 16;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Cycles spent in ARM so the synchroniser and edge history hold only fresh samples.
  function automatic int arm_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

  localparam int DEF_ARM_LEN = arm_len(DEF_SYNC_STAGES);

endpackage

// File: rtl/pll_edge_sync.sv
// Multi-flop synchroniser for one asynchronous bit plus a rising-edge detector
// on the synchronised level (one-cycle pulse per low-to-high transition).
module pll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/pll_freq_meter.sv
// Gated rising-edge counter for one of NCH asynchronous PLL clocks, with saturation
// and lock-tolerance flags. ADC_ACC_EN adds adc_in/adc_ones (ADC ones count per gate).
module pll_freq_meter
  import pll_meas_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    meas_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic [CNT_W-1:0]  expect_cnt,
  input  logic [7:0]        tol,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              lock
`ifdef ADC_ACC_EN
  ,
  input  logic              adc_in,
  output logic [GATE_W-1:0] adc_ones
`endif
);

  localparam int              ARM_W    = 8;
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(arm_len(SYNC_STAGES) - 1);

  logic [NCH-1:0] w_level;
  logic [NCH-1:0] w_rise;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_sync
    pll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (meas_in[gi]),
      .o_level (w_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  logic [1:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [GATE_W-1:0] r_gate_len;
  logic [GATE_W-1:0] r_gate;
  logic [CNT_W-1:0]  r_expect;
  logic [7:0]        r_tol;
  logic [ARM_W-1:0]  r_arm;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_int;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_lock;

  logic              w_rise_sel;
  logic [CNT_W-1:0]  w_cnt_step;
  logic              w_ovf_step;
  logic              w_publish;
  logic [CNT_W-1:0]  w_fin_cnt;
  logic              w_fin_ovf;
  logic [CNT_W-1:0]  w_fin_exp;
  logic [7:0]        w_fin_tol;
  logic [CNT_W:0]    w_diff;
  logic [CNT_W:0]    w_abs;
  logic              w_fin_lock;
  logic              w_unused;

  assign w_rise_sel = w_rise[r_sel];

  always_comb begin
    w_cnt_step = r_cnt;
    w_ovf_step = r_ovf_int;
    if (w_rise_sel) begin
      if (&r_cnt) w_ovf_step = 1'b1;
      else        w_cnt_step = r_cnt + CNT_W'(1);
    end
  end

  assign w_publish = ((r_state == ST_IDLE) && start && (gate_len == '0)) ||
                     ((r_state == ST_GATE) && (r_gate == GATE_W'(1)));

  // A zero-length gate publishes straight from the start inputs, before capture lands.
  always_comb begin
    w_fin_cnt = w_cnt_step;
    w_fin_ovf = w_ovf_step;
    w_fin_exp = r_expect;
    w_fin_tol = r_tol;
    if (r_state == ST_IDLE) begin
      w_fin_cnt = '0;
      w_fin_ovf = 1'b0;
      w_fin_exp = expect_cnt;
      w_fin_tol = tol;
    end
  end

  assign w_diff     = {1'b0, w_fin_cnt} - {1'b0, w_fin_exp};
  assign w_abs      = w_diff[CNT_W] ? -w_diff : w_diff;
  assign w_fin_lock = !w_fin_ovf && (w_abs <= {{(CNT_W-7){1'b0}}, w_fin_tol});

`ifdef ADC_ACC_EN
  logic              w_adc_level;
  logic              w_adc_rise;
  logic [GATE_W-1:0] r_adc_acc;
  logic [GATE_W-1:0] r_adc_ones;
  logic [GATE_W-1:0] w_fin_adc;

  pll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adc_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (adc_in),
    .o_level (w_adc_level),
    .o_rise  (w_adc_rise)
  );

  assign w_fin_adc = (r_state == ST_GATE) ? r_adc_acc + GATE_W'(w_adc_level) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_adc_acc  <= '0;
      r_adc_ones <= '0;
    end else begin
      if (r_state == ST_IDLE && start) r_adc_acc <= '0;
      else if (r_state == ST_GATE)     r_adc_acc <= r_adc_acc + GATE_W'(w_adc_level);
      if (w_publish) r_adc_ones <= w_fin_adc;
    end
  end

  assign adc_ones = r_adc_ones;
  assign w_unused = &{1'b0, w_level, w_adc_rise};
`else
  assign w_unused = &{1'b0, w_level};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_gate_len <= '0;
      r_gate     <= '0;
      r_expect   <= '0;
      r_tol      <= '0;
      r_arm      <= '0;
      r_cnt      <= '0;
      r_ovf_int  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel      <= sel;
            r_gate_len <= gate_len;
            r_expect   <= expect_cnt;
            r_tol      <= tol;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_ovf_int  <= 1'b0;
            r_arm      <= ARM_LOAD;
            r_state    <= (gate_len == '0) ? ST_DONE : ST_ARM;
          end
        end
        ST_ARM: begin
          if (r_arm == '0) begin
            r_state <= ST_GATE;
            r_gate  <= r_gate_len;
          end else begin
            r_arm <= r_arm - ARM_W'(1);
          end
        end
        ST_GATE: begin
          r_cnt     <= w_cnt_step;
          r_ovf_int <= w_ovf_step;
          r_gate    <= r_gate - GATE_W'(1);
          if (r_gate == GATE_W'(1)) r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_publish) begin
        r_done  <= 1'b1;
        r_count <= w_fin_cnt;
        r_ovf   <= w_fin_ovf;
        r_lock  <= w_fin_lock;
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign lock  = r_lock;

endmodule

// File: tb/tb_pll_freq_meter.sv
// Scoreboard bench for pll_freq_meter: periodic test clocks on every channel, expected
// results from edge arithmetic (gate_len / period) pushed at start, checked on done.
module tb_pll_freq_meter;

  localparam int NCH    = 4;
  localparam int GATE_W = 16;
  localparam int CNT_W  = 8;
  localparam int SS     = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    meas_in = '0;
  logic [1:0]        sel = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  expect_cnt = '0;
  logic [7:0]        tol = '0;
  logic              busy, done, ovf, lock;
  logic [CNT_W-1:0]  count;
`ifdef ADC_ACC_EN
  logic              adc_in = 1'b0;
  logic [GATE_W-1:0] adc_ones;
`endif

  pll_freq_meter #(
    .NCH(NCH), .GATE_W(GATE_W), .CNT_W(CNT_W), .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_in    (meas_in),
    .sel        (sel),
    .gate_len   (gate_len),
    .start      (start),
    .expect_cnt (expect_cnt),
    .tol        (tol),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .ovf        (ovf),
    .lock       (lock)
`ifdef ADC_ACC_EN
    ,
    .adc_in     (adc_in),
    .adc_ones   (adc_ones)
`endif
  );

  always #5 clk = ~clk;

  // Half-periods in clk cycles: channel periods are 4, 8, 6 and 10 clk cycles.
  int half_per[NCH] = '{2, 4, 3, 5};

  initial begin : gen_meas
    int ph[NCH];
    for (int c = 0; c < NCH; c++) ph[c] = 0;
    forever begin
      @(posedge clk);
      #3;
      for (int c = 0; c < NCH; c++) begin
        ph[c]++;
        if (ph[c] == half_per[c]) begin
          ph[c] = 0;
          meas_in[c] = ~meas_in[c];
        end
      end
    end
  end

  typedef struct {
    int cnt;
    int ovf;
    int lock;
    int busy;
    int adc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   busy_run = 0;
  int   last_cnt = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Gate lengths are whole periods, so exactly gate_len/period rising edges fall in the gate.
  function automatic exp_t model(input int period, input int gl, input int ex,
                                 input int tl, input int adc);
    exp_t e;
    int   edges;
    int   diff;
    edges  = (gl == 0) ? 0 : gl / period;
    e.cnt  = (edges > CMAX) ? CMAX : edges;
    e.ovf  = (edges > CMAX) ? 1 : 0;
    diff   = e.cnt - ex;
    if (diff < 0) diff = -diff;
    e.lock = (e.ovf == 0 && diff <= tl) ? 1 : 0;
    e.busy = (gl == 0) ? 1 : gl + SS + 2;
    e.adc  = adc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n)    busy_run = 0;
    else if (busy) busy_run++;
    else           busy_run = 0;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("count", int'(count), mon_e.cnt);
        chk("ovf", int'(ovf), mon_e.ovf);
        chk("lock", int'(lock), mon_e.lock);
        chk("busy_cycles", busy_run, mon_e.busy);
`ifdef ADC_ACC_EN
        chk("adc_ones", int'(adc_ones), mon_e.adc);
`endif
        last_cnt = mon_e.cnt;
        $display("txn done: count=%0d ovf=%0d lock=%0d busy_cycles=%0d", count, ovf, lock, busy_run);
      end
    end
  end

  task automatic issue(input int ch, input int gl, input int ex, input int tl, input int adc_exp);
    chk("count_hold", int'(count), last_cnt);
    @(negedge clk);
    sel        = 2'(ch);
    gate_len   = GATE_W'(gl);
    expect_cnt = CNT_W'(ex);
    tol        = 8'(tl);
    start      = 1'b1;
    sb.push_back(model(half_per[ch] * 2, gl, ex, tl, adc_exp));
    $display("txn start: ch=%0d gate=%0d expect=%0d tol=%0d", ch, gl, ex, tl);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_lock"}, int'(lock), 0);
  endtask

  initial begin : main
    exp_t dropped;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    issue(1, 800, 100, 0, 0);   wait_done();
    issue(1, 800, 103, 2, 0);   wait_done();
    issue(1, 800, 103, 3, 0);   wait_done();
    issue(0, 2000, 0, 0, 0);    wait_done();
    issue(0, 0, 1, 1, 0);       wait_done();
    issue(2, 0, 2, 1, 0);       wait_done();

    // Extra start mid-gate must not disturb the running measurement.
    issue(2, 600, 100, 0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    sel = 2'd0; gate_len = '0; expect_cnt = 8'd5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();

    // Reset mid-gate abandons the measurement without a done pulse.
    issue(3, 500, 50, 0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    dropped = sb.pop_back();
    @(negedge clk) rst_n = 1'b1;
    last_cnt = 0;
    chk_all_zero("midreset");
    repeat (700) @(posedge clk);
    issue(1, 80, 10, 0, 0);     wait_done();

`ifdef ADC_ACC_EN
    adc_in = 1'b1;
    issue(1, 800, 100, 0, 300);
    repeat (301) @(posedge clk);
    #3 adc_in = 1'b0;
    wait_done();
`endif

    for (int i = 0; i < 20; i++) begin
      int ch, k, gl, ex, tl;
      ch = int'($urandom_range(0, 3));
      k  = (ch == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 60));
      gl = k * half_per[ch] * 2;
      ex = k + int'($urandom_range(0, 8)) - 4;
      if (ex < 0)    ex = 0;
      if (ex > CMAX) ex = CMAX;
      tl = int'($urandom_range(0, 5));
      issue(ch, gl, ex, tl, 0);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
